// File: rtl/hive_rbus_arb.sv
// hive_rbus_arb: register bus arbiter. The core owns the bus outright; a debug
// master gets a slot only in cycles the core leaves idle. Debug reads are tagged
// through a shift register so returning data is routed to the debug port
// instead of the core.
module hive_rbus_arb #(
  parameter int RBUS_ADDR_W = 8,
  parameter int ALU_W       = 32,
  parameter int RD_LAT      = 1,
  parameter int WAIT_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RBUS_ADDR_W-1:0] core_addr_i,
  input  logic                   core_wr_i,
  input  logic                   core_rd_i,
  input  logic [ALU_W-1:0]       core_wr_data_i,
  output logic [ALU_W-1:0]       core_rd_data_o,
  input  logic                   dbg_req_i,
  input  logic                   dbg_we_i,
  input  logic [RBUS_ADDR_W-1:0] dbg_addr_i,
  input  logic [ALU_W-1:0]       dbg_wr_data_i,
  output logic                   dbg_ack_o,
  output logic                   dbg_busy_o,
  output logic [ALU_W-1:0]       dbg_rd_data_o,
  output logic                   dbg_rd_vld_o,
  output logic [WAIT_W-1:0]      dbg_wait_o,
  output logic [RBUS_ADDR_W-1:0] rbus_addr_o,
  output logic                   rbus_wr_o,
  output logic                   rbus_rd_o,
  output logic [ALU_W-1:0]       rbus_wr_data_o,
  input  logic [ALU_W-1:0]       rbus_rd_data_i
);

  typedef enum logic [1:0] {IDLE, PEND, RDWAIT} state_t;

  state_t                 state_q;
  logic                   cmd_we_q;
  logic [RBUS_ADDR_W-1:0] cmd_addr_q;
  logic [ALU_W-1:0]       cmd_wdata_q;
  logic [WAIT_W-1:0]      wait_q;
  logic [ALU_W-1:0]       rd_data_q;
  logic                   rd_vld_q;
  logic                   ack_q;
  logic [RBUS_ADDR_W-1:0] addr_q;
  logic                   wr_q;
  logic                   rd_q;
  logic [ALU_W-1:0]       wdata_q;
  logic                   slot_q;
  logic [RD_LAT-1:0]      tag_q;

  logic core_cmd_d;
  logic issue_d;
  logic ret_dbg_d;

  // Saturating increment: the wait counter sticks at all-ones instead of wrapping.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    if (&v) return v;
    return v + {{(WAIT_W-1){1'b0}}, 1'b1};
  endfunction

  // A debug command may only take the slot when the core leaves it empty.
  always_comb begin
    core_cmd_d = core_wr_i | core_rd_i;
    issue_d    = (state_q == PEND) && !core_cmd_d;
    ret_dbg_d  = tag_q[RD_LAT-1];
  end

  // Register the bus: core first, then a pending debug command, else all zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      slot_q  <= 1'b0;
    end else if (core_cmd_d) begin
      addr_q  <= core_addr_i;
      wr_q    <= core_wr_i;
      rd_q    <= core_rd_i;
      wdata_q <= core_wr_data_i;
      ack_q   <= 1'b0;
      slot_q  <= 1'b0;
    end else if (issue_d) begin
      addr_q  <= cmd_addr_q;
      wr_q    <= cmd_we_q;
      rd_q    <= !cmd_we_q;
      wdata_q <= cmd_we_q ? cmd_wdata_q : '0;
      ack_q   <= 1'b1;
      slot_q  <= !cmd_we_q;
    end else begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      slot_q  <= 1'b0;
    end
  end

  // Tag pipeline: the last stage lines up with the cycle the slave data returns.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= slot_q;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Debug FSM: latch a request, wait for a free slot, collect read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dbg_req_i) begin
            cmd_we_q    <= dbg_we_i;
            cmd_addr_q  <= dbg_addr_i;
            cmd_wdata_q <= dbg_wr_data_i;
            wait_q      <= '0;
            state_q     <= PEND;
          end
        end
        PEND: begin
          if (core_cmd_d) wait_q <= sat_inc(wait_q);
          else            state_q <= cmd_we_q ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (ret_dbg_d) begin
            rd_data_q <= rbus_rd_data_i;
            rd_vld_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_rd_data_o = ret_dbg_d ? '0 : rbus_rd_data_i;
  assign dbg_ack_o      = ack_q;
  assign dbg_busy_o     = (state_q != IDLE);
  assign dbg_rd_data_o  = rd_data_q;
  assign dbg_rd_vld_o   = rd_vld_q;
  assign dbg_wait_o     = wait_q;
  assign rbus_addr_o    = addr_q;
  assign rbus_wr_o      = wr_q;
  assign rbus_rd_o      = rd_q;
  assign rbus_wr_data_o = wdata_q;

endmodule

// File: tb/tb_hive_rbus_arb.sv
// Scoreboard bench for hive_rbus_arb: stimulus pushes expected bus cycles,
// read returns, debug read data and status snapshots; one monitor pops and
// compares them on the falling edge.
module tb_hive_rbus_arb;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD_LAT = 2;
  localparam int WAIT_W = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [AW-1:0] core_addr_i = '0;
  logic core_wr_i = 1'b0, core_rd_i = 1'b0;
  logic [DW-1:0] core_wr_data_i = '0;
  logic [DW-1:0] core_rd_data_o;
  logic dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [AW-1:0] dbg_addr_i = '0;
  logic [DW-1:0] dbg_wr_data_i = '0;
  logic dbg_ack_o, dbg_busy_o, dbg_rd_vld_o;
  logic [DW-1:0] dbg_rd_data_o;
  logic [WAIT_W-1:0] dbg_wait_o;
  logic [AW-1:0] rbus_addr_o;
  logic rbus_wr_o, rbus_rd_o;
  logic [DW-1:0] rbus_wr_data_o;
  logic [DW-1:0] rbus_rd_data_i;

  always #5 clk = ~clk;

  hive_rbus_arb #(.RBUS_ADDR_W(AW), .ALU_W(DW), .RD_LAT(RD_LAT), .WAIT_W(WAIT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_addr_i(core_addr_i), .core_wr_i(core_wr_i), .core_rd_i(core_rd_i),
    .core_wr_data_i(core_wr_data_i), .core_rd_data_o(core_rd_data_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wr_data_i(dbg_wr_data_i), .dbg_ack_o(dbg_ack_o), .dbg_busy_o(dbg_busy_o),
    .dbg_rd_data_o(dbg_rd_data_o), .dbg_rd_vld_o(dbg_rd_vld_o), .dbg_wait_o(dbg_wait_o),
    .rbus_addr_o(rbus_addr_o), .rbus_wr_o(rbus_wr_o), .rbus_rd_o(rbus_rd_o),
    .rbus_wr_data_o(rbus_wr_data_o), .rbus_rd_data_i(rbus_rd_data_i)
  );

  // Slave model: fixed-latency read pipe, data chosen by address.
  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    case (a)
      8'h30:   return 32'h0000_1234;
      8'h40:   return 32'h0000_AAAA;
      8'h41:   return 32'h0000_5555;
      default: return 32'hC000_0000 | {24'h0, a};
    endcase
  endfunction

  logic [RD_LAT-1:0] sl_vld = '0;
  logic [DW-1:0] sl_dat [RD_LAT] = '{default: '0};
  always @(posedge clk) begin
    sl_vld[0] <= rbus_rd_o;
    sl_dat[0] <= rbus_rd_o ? slave_data(rbus_addr_o) : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      sl_vld[i] <= sl_vld[i-1];
      sl_dat[i] <= sl_dat[i-1];
    end
  end
  assign rbus_rd_data_i = sl_vld[RD_LAT-1] ? sl_dat[RD_LAT-1] : '0;

  // Scoreboard queues
  typedef struct packed {
    logic wr; logic rd; logic [AW-1:0] addr; logic [DW-1:0] data; logic ack;
  } bus_t;
  typedef struct {
    string nm; int sel; logic [DW-1:0] val;
  } st_t;

  bus_t exp_bus[$];
  logic [DW-1:0] exp_ret[$];
  logic [DW-1:0] exp_dvld[$];
  st_t exp_st[$];

  int checks = 0;
  int failures = 0;
  logic end_chk = 1'b0;
  logic done = 1'b0;

  function automatic logic [DW-1:0] status(input int sel);
    case (sel)
      0:       return {31'b0, dbg_busy_o};
      1:       return 32'(dbg_wait_o);
      2:       return dbg_rd_data_o;
      3:       return {31'b0, |{rbus_wr_o, rbus_rd_o, rbus_addr_o, rbus_wr_data_o}};
      4:       return {31'b0, dbg_rd_vld_o};
      default: return {31'b0, dbg_ack_o};
    endcase
  endfunction

  // Monitor: compare every DUT presentation against the scoreboard.
  bus_t got, e;
  st_t s;
  logic [DW-1:0] ev;
  always @(negedge clk) begin
    got = {rbus_wr_o, rbus_rd_o, rbus_addr_o, rbus_wr_data_o, dbg_ack_o};
    if (rbus_wr_o || rbus_rd_o) begin
      checks++;
      if (exp_bus.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected got=%h required=none", got);
      end else begin
        e = exp_bus.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL bus_cycle got=%h required=%h", got, e);
        end
      end
    end else if (!rst_i) begin
      checks++;
      if ({rbus_addr_o, rbus_wr_data_o, dbg_ack_o} !== '0) begin
        failures++;
        $display("FAIL idle_slot addr=%h data=%h ack=%b required=0", rbus_addr_o, rbus_wr_data_o, dbg_ack_o);
      end
    end
    if (sl_vld[RD_LAT-1]) begin
      checks++;
      if (exp_ret.size() == 0) begin
        failures++;
        $display("FAIL ret_unexpected core_rd_data=%h", core_rd_data_o);
      end else begin
        ev = exp_ret.pop_front();
        if (core_rd_data_o !== ev) begin
          failures++;
          $display("FAIL core_rd_data got=%h required=%h", core_rd_data_o, ev);
        end
      end
    end
    if (dbg_rd_vld_o) begin
      checks++;
      if (exp_dvld.size() == 0) begin
        failures++;
        $display("FAIL dbg_vld_unexpected data=%h", dbg_rd_data_o);
      end else begin
        ev = exp_dvld.pop_front();
        if (dbg_rd_data_o !== ev) begin
          failures++;
          $display("FAIL dbg_rd_data got=%h required=%h", dbg_rd_data_o, ev);
        end
      end
    end
    while (exp_st.size() > 0) begin
      s = exp_st.pop_front();
      checks++;
      if (status(s.sel) !== s.val) begin
        failures++;
        $display("FAIL %s got=%h required=%h", s.nm, status(s.sel), s.val);
      end
    end
    if (end_chk && !done) begin
      checks++;
      if (exp_bus.size() != 0 || exp_ret.size() != 0 || exp_dvld.size() != 0) begin
        failures++;
        $display("FAIL leftover bus=%0d ret=%0d dvld=%0d required=0", exp_bus.size(), exp_ret.size(), exp_dvld.size());
      end
      done = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expst(input string nm, input int sel, input logic [DW-1:0] v);
    st_t t;
    t.nm = nm; t.sel = sel; t.val = v;
    exp_st.push_back(t);
  endtask

  task automatic pbus(input logic wr, input logic rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic ack);
    exp_bus.push_back({wr, rd, a, d, ack});
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && dbg_busy_o; n++) cyc();
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    expst("rst_busy", 0, 0);
    expst("rst_wait", 1, 0);
    expst("rst_rddata", 2, 0);
    expst("rst_bus", 3, 0);
    expst("rst_vld", 4, 0);
    expst("rst_ack", 5, 0);
    rst_i = 1'b0;
    cyc();

    // Plain core write
    core_wr_i = 1'b1; core_addr_i = 8'h10; core_wr_data_i = 32'hDEADBEEF;
    pbus(1, 0, 8'h10, 32'hDEADBEEF, 0);
    cyc();
    core_wr_i = 1'b0; core_addr_i = '0; core_wr_data_i = '0;
    expst("cw_busy", 0, 0);
    repeat (2) cyc();

    // Debug write held off by three core reads
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 8'h20; dbg_wr_data_i = 32'h5;
    cyc();
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = 8'hEE; dbg_wr_data_i = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      core_rd_i = 1'b1; core_addr_i = 8'h50 + 8'(i);
      pbus(0, 1, 8'h50 + 8'(i), 0, 0);
      exp_ret.push_back(slave_data(8'h50 + 8'(i)));
      cyc();
    end
    core_rd_i = 1'b0; core_addr_i = '0;
    pbus(1, 0, 8'h20, 32'h5, 1);
    expst("dw_wait", 1, 3);
    expst("dw_busy", 0, 1);
    cyc();
    expst("dw_busy_after", 0, 0);
    expst("dw_wait_hold", 1, 3);
    repeat (4) cyc();

    // Debug read
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 8'h30;
    pbus(0, 1, 8'h30, 0, 1);
    exp_ret.push_back(32'h0);
    exp_dvld.push_back(32'h1234);
    cyc();
    dbg_req_i = 1'b0;
    wait_idle(20);
    expst("dr_busy", 0, 0);
    expst("dr_data", 2, 32'h1234);
    repeat (3) cyc();
    expst("dr_hold", 2, 32'h1234);
    expst("dr_vld_low", 4, 0);

    // Core read and debug read in adjacent slots, then a held request
    core_rd_i = 1'b1; core_addr_i = 8'h40;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 8'h41;
    pbus(0, 1, 8'h40, 0, 0);
    pbus(0, 1, 8'h41, 0, 1);
    pbus(1, 0, 8'h22, 32'h77, 1);
    exp_ret.push_back(32'hAAAA);
    exp_ret.push_back(32'h0);
    exp_dvld.push_back(32'h5555);
    cyc();
    core_rd_i = 1'b0; core_addr_i = '0;
    dbg_we_i = 1'b1; dbg_addr_i = 8'h22; dbg_wr_data_i = 32'h77;
    for (int n = 0; n < 20 && !dbg_rd_vld_o; n++) cyc();
    expst("adj_data", 2, 32'h5555);
    cyc();
    dbg_req_i = 1'b0; dbg_addr_i = 8'hFF; dbg_wr_data_i = '0;
    expst("adj_busy_pend", 0, 1);
    cyc();
    expst("adj_busy_done", 0, 0);
    repeat (3) cyc();

    // Wait counter saturation
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 8'h60; dbg_wr_data_i = 32'h99;
    cyc();
    dbg_req_i = 1'b0;
    for (int i = 0; i < (1 << WAIT_W) + 5; i++) begin
      core_wr_i = 1'b1; core_addr_i = 8'h70; core_wr_data_i = 32'(i);
      pbus(1, 0, 8'h70, 32'(i), 0);
      if (i == 15) expst("sat_wait15", 1, 32'hF);
      cyc();
    end
    core_wr_i = 1'b0; core_addr_i = '0; core_wr_data_i = '0;
    expst("sat_wait", 1, 32'hF);
    expst("sat_busy", 0, 1);
    pbus(1, 0, 8'h60, 32'h99, 1);
    cyc();
    expst("sat_busy_after", 0, 0);
    expst("sat_wait_after", 1, 32'hF);
    repeat (2) cyc();

    // Reset in RDWAIT
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 8'h30;
    pbus(0, 1, 8'h30, 0, 1);
    exp_ret.push_back(32'h1234);
    cyc();
    dbg_req_i = 1'b0;
    cyc();
    rst_i = 1'b1;
    expst("rdw_busy", 0, 1);
    cyc();
    rst_i = 1'b0;
    expst("rdw_rst_busy", 0, 0);
    expst("rdw_rst_vld", 4, 0);
    expst("rdw_rst_bus", 3, 0);
    expst("rdw_rst_wait", 1, 0);
    repeat (4) cyc();
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 8'h24; dbg_wr_data_i = 32'h11;
    pbus(1, 0, 8'h24, 32'h11, 1);
    cyc();
    dbg_req_i = 1'b0;
    wait_idle(10);
    expst("post_rst_busy", 0, 0);
    repeat (3) cyc();

    end_chk = 1'b1;
    for (int n = 0; n < 10 && !done; n++) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
